// File: rtl/memory_grant_arbiter.sv
// ---------------------------------------------------------------------------
// memory_grant_arbiter
//
// Round-robin arbiter that shares the single main-memory port among N_REQ
// control units. A unit raises its request and holds it for a whole burst.
// The arbiter answers with a registered one-hot grant and keeps that grant
// until the owner drops its request. After every release it leaves one dead
// cycle so the old owner's memory enables can settle.
//
// Optional feature: define ARBITER_TIMEOUT_EN to enable the hold watchdog.
//   - The watchdog revokes a grant after TIMEOUT cycles.
//   - It raises the sticky o_Timeout flag.
//   - It masks the stuck requester until that requester deasserts.
//   Without the macro there is no counter and no mask, o_Timeout is tied
//   to 0, and grants are unbounded.
//
// Ports
//   i_Clock        in   1          clock, rising edge
//   i_Reset        in   1          asynchronous, active-low reset
//   i_Request      in   N_REQ      per-unit request level, held for a burst
//   o_Grant        out  N_REQ      registered one-hot grant
//   o_Grant_Valid  out  1          OR of o_Grant
//   o_Grant_Index  out  N_REQ_LOG  index of the current/last owner (mux select)
//   o_Timeout      out  1          sticky watchdog flag
// ---------------------------------------------------------------------------
module memory_grant_arbiter #(
    parameter int N_REQ       = 4,
    parameter int N_REQ_LOG   = 2,
    parameter int TIMEOUT     = 64,
    parameter int TIMEOUT_LOG = 7
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [N_REQ-1:0]     i_Request,
    output logic [N_REQ-1:0]     o_Grant,
    output logic                 o_Grant_Valid,
    output logic [N_REQ_LOG-1:0] o_Grant_Index,
    output logic                 o_Timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [N_REQ_LOG-1:0] ptr;
    logic [N_REQ_LOG-1:0] ptr_next;
    logic [N_REQ-1:0]     grant_next;
    logic [N_REQ_LOG-1:0] index_next;
    logic [N_REQ-1:0]     mask;
    logic [N_REQ-1:0]     eligible;
    logic [N_REQ_LOG-1:0] winner;
    logic [N_REQ_LOG-1:0] cand;
    logic                 found;
    logic [N_REQ_LOG-1:0] owner_succ;
    logic                 owner_req;

`ifdef ARBITER_TIMEOUT_EN
    localparam logic [TIMEOUT_LOG-1:0] HOLD_LAST = TIMEOUT_LOG'(TIMEOUT - 1);

    logic [TIMEOUT_LOG-1:0] hold_count;
    logic [TIMEOUT_LOG-1:0] hold_count_next;
    logic [N_REQ-1:0]       mask_next;
    logic                   timeout_flag;
    logic                   timeout_next;
`else
    // The watchdog parameters have no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^(TIMEOUT_LOG'(TIMEOUT));
    assign mask = '0;
    assign o_Timeout = 1'b0;
`endif

    assign eligible      = i_Request & ~mask;
    assign o_Grant_Valid = |o_Grant;
    assign owner_req     = i_Request[o_Grant_Index];

    // Successor of the current owner.
    // Written as an explicit wrap so that N_REQ need not be a power of two.
    assign owner_succ = (o_Grant_Index == N_REQ_LOG'(N_REQ - 1)) ?
                        '0 : o_Grant_Index + 1'b1;

    // Round-robin pick: the first eligible request at or after ptr, modulo N_REQ.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = N_REQ_LOG'((int'(ptr) + i) % N_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and next-output logic.
    // A release always advances ptr past the owner. A re-raised request from
    // that owner therefore has the lowest priority on the next arbitration.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = o_Grant;
        index_next = o_Grant_Index;
`ifdef ARBITER_TIMEOUT_EN
        hold_count_next = hold_count;
        timeout_next    = timeout_flag;
        // A masked requester is forgiven once it deasserts.
        mask_next       = mask & i_Request;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_next         = '0;
                    grant_next[winner] = 1'b1;
                    index_next         = winner;
                    state_next         = S_GRANT;
`ifdef ARBITER_TIMEOUT_EN
                    hold_count_next    = '0;
`endif
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    grant_next = '0;
                    ptr_next   = owner_succ;
                    state_next = S_RELEASE;
                end
`ifdef ARBITER_TIMEOUT_EN
                else if (hold_count == HOLD_LAST) begin
                    grant_next               = '0;
                    ptr_next                 = owner_succ;
                    state_next               = S_RELEASE;
                    timeout_next             = 1'b1;
                    mask_next[o_Grant_Index] = 1'b1;
                end else begin
                    hold_count_next = hold_count + 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                grant_next = '0;
                state_next = S_IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    // Reset clears the grant immediately, without waiting for a clock edge.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            o_Grant       <= '0;
            o_Grant_Index <= '0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            o_Grant       <= grant_next;
            o_Grant_Index <= index_next;
        end
    end

`ifdef ARBITER_TIMEOUT_EN
    // Watchdog registers: hold counter, stuck-requester mask, sticky flag.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            hold_count   <= '0;
            mask         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            hold_count   <= hold_count_next;
            mask         <= mask_next;
            timeout_flag <= timeout_next;
        end
    end

    assign o_Timeout = timeout_flag;
`endif

endmodule
